// File: rtl/load_store_unit.sv
// load_store_unit
// ---------------------------------------------------------------------------
// Initiator side of the data-memory interface. Takes one load or store at a
// time from the datapath (RV64 funct3 encodings), drives the memory's
// mem_read / mem_write / endereco / write_data, and returns sign- or
// zero-extended load results.
//
// The memory is byte-addressed, big-endian, and always moves an 8-byte window
// at addr..addr+7 (mod 2**ADDR_W). The accessed field is therefore always the
// most significant 8N bits of the window. Stores narrower than a doubleword
// are done as read-modify-write: READ -> MERGE -> WRITE.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE; req_valid seen while busy is ignored, not
// queued. resp_valid is a one-cycle pulse; resp_err qualifies it. load_data
// holds its value until the next load response.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     request handshake
//   req_store           1 = store, 0 = load
//   req_funct3          RV64 load/store width/sign encoding
//   req_addr            byte address
//   req_wdata           store data (low 8N bits used)
//   resp_valid/err      completion pulse / illegal-funct3 flag
//   load_data           extended load result
//   mem_read/mem_write  memory strobes (never both high)
//   endereco            window address to memory
//   write_data          big-endian doubleword to memory
//   read_data           doubleword from memory, valid in a mem_read cycle
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                store_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   buf_q;
    logic [DATA_W-1:0]   load_data_q;

    logic                req_illegal;
    logic                req_is_sd;
    logic [6:0]          shift_amt;
    logic [DATA_W-1:0]   field_mask;
    logic [DATA_W-1:0]   merged;
    logic [DATA_W-1:0]   ext_data;

    // Loads only reserve 111; stores only define 000..011.
    assign req_illegal = req_store ? req_funct3[2] : (req_funct3 == 3'b111);
    assign req_is_sd   = req_store && (req_funct3 == 3'b011);

    // The field sits at the top of the window, so the store data must be
    // shifted up by (DATA_W - 8N) to line up with it.
    always_comb begin
        shift_amt = 7'd0;
        case (funct3_q[1:0])
            2'b00:   shift_amt = 7'(DATA_W - 8);
            2'b01:   shift_amt = 7'(DATA_W - 16);
            2'b10:   shift_amt = 7'(DATA_W - 32);
            default: shift_amt = 7'd0;
        endcase
    end

    assign field_mask = {DATA_W{1'b1}} << shift_amt;
    assign merged     = (buf_q & ~field_mask) | ((wdata_q << shift_amt) & field_mask);

    // Extension of the top-aligned field taken straight from read_data, so
    // load_data is ready on entry to RESP.
    always_comb begin
        ext_data = read_data;
        case (funct3_q)
            3'b000:  ext_data = {{(DATA_W-8){read_data[DATA_W-1]}},  read_data[DATA_W-1 -: 8]};
            3'b001:  ext_data = {{(DATA_W-16){read_data[DATA_W-1]}}, read_data[DATA_W-1 -: 16]};
            3'b010:  ext_data = {{(DATA_W-32){read_data[DATA_W-1]}}, read_data[DATA_W-1 -: 32]};
            3'b100:  ext_data = {{(DATA_W-8){1'b0}},  read_data[DATA_W-1 -: 8]};
            3'b101:  ext_data = {{(DATA_W-16){1'b0}}, read_data[DATA_W-1 -: 16]};
            3'b110:  ext_data = {{(DATA_W-32){1'b0}}, read_data[DATA_W-1 -: 32]};
            default: ext_data = read_data;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_illegal) begin
                        state_d = S_ERR;
                    end else if (req_is_sd) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = store_q ? S_MERGE : S_RESP;
            S_MERGE: state_d = S_WRITE;
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        // A full doubleword store skips the read; the store
                        // data is the whole window.
                        if (req_is_sd) begin
                            buf_q <= req_wdata;
                        end
                    end
                end
                S_READ: begin
                    buf_q <= read_data;
                    if (!store_q) begin
                        load_data_q <= ext_data;
                    end
                end
                S_MERGE: begin
                    buf_q <= merged;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are decoded from state; endereco and write_data come straight
    // from registers, so they are stable across the whole READ/WRITE cycle.
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
    assign resp_err   = (state_q == S_ERR);
    assign mem_read   = (state_q == S_READ);
    assign mem_write  = (state_q == S_WRITE);
    assign endereco   = addr_q;
    assign write_data = buf_q;
    assign load_data  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// ---------------------------------------------------------------------------
// Bench for load_store_unit. A 256-byte big-endian memory is modelled around
// the DUT; a separate byte array holds the expected memory image, updated
// from the architectural meaning of each load/store.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] load_data;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  endereco;
    logic [63:0] write_data;
    logic [63:0] read_data;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.ADDR_W(8), .DATA_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .load_data  (load_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .endereco   (endereco),
        .write_data (write_data),
        .read_data  (read_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory around the DUT ----------------
    logic [7:0] mem [256];
    logic       preload;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            7:       return 8'h08;
            15:      return 8'h06;
            22:      return 8'h5A;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        end else if (mem_write) begin
            for (int k = 0; k < 8; k++) mem[8'(endereco + 8'(k))] <= write_data[63-8*k -: 8];
        end
    end

    always_comb begin
        read_data = '0;
        if (mem_read) begin
            for (int k = 0; k < 8; k++) read_data[63-8*k -: 8] = mem[8'(endereco + 8'(k))];
        end
    end

    // ---------------- bus monitor ----------------
    int          rd_cnt   = 0;
    int          wr_cnt   = 0;
    int          both_cnt = 0;
    logic [7:0]  last_wr_addr = '0;
    logic [63:0] last_wr_data = '0;

    always @(negedge clk) begin
        if (!reset && !preload) begin
            if (mem_read)  rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                last_wr_addr = endereco;
                last_wr_data = write_data;
            end
            if (mem_read && mem_write) both_cnt++;
        end
    end

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [256];
    logic [63:0] exp_load;

    // Architectural effect of one request: expected error, latency, bus
    // activity and, for stores, the expected 8-byte window after the store.
    task automatic model_op(input bit st, input logic [2:0] f3, input logic [7:0] addr,
                            input logic [63:0] wd, output bit err, output int lat,
                            output int n_rd, output int n_wr, output logic [63:0] win);
        int          n;
        logic [63:0] val;
        n    = 1 << f3[1:0];
        err  = st ? f3[2] : (f3 == 3'b111);
        n_rd = 0;
        n_wr = 0;
        win  = '0;
        if (err) begin
            lat = 1;
        end else if (!st) begin
            lat  = 2;
            n_rd = 1;
            val  = 0;
            for (int k = 0; k < n; k++) val = (val << 8) | 64'(ref_mem[8'(addr + 8'(k))]);
            if (!f3[2] && n < 8 && val[8*n-1]) val = val - (64'd1 << (8*n));
            exp_load = val;
        end else begin
            lat  = (n == 8) ? 2 : 4;
            n_rd = (n == 8) ? 0 : 1;
            n_wr = 1;
            for (int k = 0; k < n; k++) ref_mem[8'(addr + 8'(k))] = 8'(wd >> (8*(n-1-k)));
            for (int k = 0; k < 8; k++) win = (win << 8) | 64'(ref_mem[8'(addr + 8'(k))]);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [63:0] wd, input bit noise);
        bit          e_err;
        int          e_lat, e_rd, e_wr, lat, rd0, wr0;
        logic [63:0] e_win;
        bit          got;
        model_op(st, f3, addr, wd, e_err, e_lat, e_rd, e_wr, e_win);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        check_val("ready_before", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) got = 1'b1;
            // Optionally keep strobing junk requests while busy; they must be ignored.
            req_valid = noise && !got;
            if (noise) begin
                req_store  = 1'($urandom_range(0, 1));
                req_funct3 = 3'($urandom_range(0, 7));
                req_addr   = 8'($urandom_range(0, 255));
                req_wdata  = {$urandom, $urandom};
            end
        end
        check_val("latency", 64'(lat), 64'(e_lat));
        check_val("resp_err", 64'(resp_err), 64'(e_err));
        check_val("load_data", load_data, exp_load);
        @(negedge clk);
        check_val("resp_pulse", 64'(resp_valid), 64'd0);
        check_val("ready_after", 64'(req_ready), 64'd1);
        check_val("rd_count", 64'(rd_cnt - rd0), 64'(e_rd));
        check_val("wr_count", 64'(wr_cnt - wr0), 64'(e_wr));
        if (e_wr != 0) begin
            check_val("wr_addr", 64'(last_wr_addr), 64'(addr));
            check_val("wr_data", last_wr_data, e_win);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        int rd0, wr0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 8'd0;
        req_wdata  = 64'd0;
        reset      = 1'b1;
        preload    = 1'b1;
        exp_load   = 64'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        preload = 1'b0;

        // Reset state
        check_val("rst_ready", 64'(req_ready), 64'd1);
        check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_val("rst_resp_err", 64'(resp_err), 64'd0);
        check_val("rst_mem_read", 64'(mem_read), 64'd0);
        check_val("rst_mem_write", 64'(mem_write), 64'd0);
        check_val("rst_load_data", load_data, 64'd0);
        check_val("rst_endereco", 64'(endereco), 64'd0);
        check_val("rst_write_data", write_data, 64'd0);

        // Directed cases
        do_op(1'b0, 3'b011, 8'd0, 64'd0, 1'b0);
        check_val("ld0_value", load_data, 64'h0000000000000008);
        do_op(1'b0, 3'b000, 8'd7, 64'd0, 1'b0);
        check_val("lb7_value", load_data, 64'h0000000000000008);

        do_op(1'b1, 3'b000, 8'd3, 64'h00000000000000AB, 1'b0);
        check_val("sb_addr", 64'(last_wr_addr), 64'd3);
        check_val("sb_wdata", last_wr_data, 64'hAB00000008000000);
        do_op(1'b0, 3'b011, 8'd0, 64'd0, 1'b0);
        check_val("ld_after_sb", load_data, 64'h000000AB00000008);

        do_op(1'b1, 3'b001, 8'd20, 64'h0000000000008001, 1'b0);
        do_op(1'b0, 3'b001, 8'd20, 64'd0, 1'b0);
        check_val("lh20", load_data, 64'hFFFFFFFFFFFF8001);
        do_op(1'b0, 3'b101, 8'd20, 64'd0, 1'b0);
        check_val("lhu20", load_data, 64'h0000000000008001);
        do_op(1'b0, 3'b100, 8'd22, 64'd0, 1'b0);
        check_val("byte22_kept", load_data, 64'h000000000000005A);

        do_op(1'b1, 3'b011, 8'd252, 64'h1122334455667788, 1'b0);
        do_op(1'b0, 3'b011, 8'd252, 64'd0, 1'b0);
        check_val("ld252", load_data, 64'h1122334455667788);
        do_op(1'b0, 3'b011, 8'd0, 64'd0, 1'b0);
        check_val("ld0_wrap_hi", 64'(load_data[63:32]), 64'h55667788);

        // Illegal store funct3: load_data must keep the previous result
        do_op(1'b1, 3'b100, 8'd40, 64'hFFFF, 1'b0);
        check_val("err_load_kept", 64'(load_data[63:32]), 64'h55667788);
        do_op(1'b0, 3'b111, 8'd41, 64'd0, 1'b0);

        // Reset during MERGE of sw addr 8
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 8'd8;
        req_wdata  = 64'h00000000DEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_val("mid_read", 64'(mem_read), 64'd1);
        @(negedge clk);
        check_val("mid_merge_quiet", 64'({mem_read, mem_write}), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_load = 64'd0;
        check_val("mid_ready", 64'(req_ready), 64'd1);
        check_val("mid_no_resp", 64'(resp_valid), 64'd0);
        repeat (3) @(negedge clk);
        check_val("mid_still_no_resp", 64'(resp_valid), 64'd0);
        check_val("mid_no_write", 64'(wr_cnt - wr0), 64'd0);
        check_val("mid_one_read", 64'(rd_cnt - rd0), 64'd1);
        do_op(1'b0, 3'b011, 8'd8, 64'd0, 1'b0);
        check_val("ld8_after_reset", load_data, 64'h0000000000000006);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)));
        end

        // Final memory image and bus exclusivity
        check_val("never_both", 64'(both_cnt), 64'd0);
        for (int i = 0; i < 256; i++) begin
            check_val($sformatf("mem[%0d]", i), 64'(mem[i]), 64'(ref_mem[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
